// File: rtl/multi_ctrl.sv
// Multicycle MIPS-style control FSM: Moore datapath strobes per state; pcEn/irWrite gated by memReady/zero; addi via MULTI_CTRL_ADDI_EN.
// One state per clk; FETCH, MEMRD and MEMWR stall while memReady=0. Async active-low reset forces FETCH with pcEn/irWrite held low.
module multi_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic [3:0] aluCtr,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic       pcEn,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       illegalOp,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MULTI_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
`endif

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    logic [3:0] r_state;
    logic [3:0] r_alu_ctr;
    logic [3:0] w_next_state;
    logic [3:0] w_decode_next;
    logic       w_op_illegal;
    logic [3:0] w_funct_alu;
    logic       w_funct_ok;

    // R-type function decode; unknown funct falls back to ADD and is flagged.
    always_comb begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b1;
        case (funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            FN_NOR:  w_funct_alu = ALU_NOR;
            default: begin
                w_funct_alu = ALU_ADD;
                w_funct_ok  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_decode_next = S_FETCH;
        w_op_illegal  = 1'b0;
        case (opCode)
            OP_LW, OP_SW: w_decode_next = S_MEMADR;
            OP_RTYPE:     w_decode_next = S_EXEC;
            OP_BEQ:       w_decode_next = S_BRANCH;
            OP_J:         w_decode_next = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
            OP_ADDI:      w_decode_next = S_ADDIEX;
`else
            OP_ADDI: begin
                w_decode_next = S_FETCH;
                w_op_illegal  = 1'b1;
            end
`endif
            default: begin
                w_decode_next = S_FETCH;
                w_op_illegal  = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = memReady ? S_DECODE : S_FETCH;
            S_DECODE: w_next_state = w_decode_next;
            S_MEMADR: w_next_state = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next_state = w_funct_ok ? S_RWB : S_FETCH;
            S_RWB:    w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_JUMP:   w_next_state = S_FETCH;
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: w_next_state = S_FETCH;
`endif
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ALU op chosen in EXEC is held so RWB sees the same operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ctr <= ALU_ADD;
        end else if (r_state == S_EXEC) begin
            r_alu_ctr <= w_funct_alu;
        end
    end

    always_comb begin
        aluCtr    = ALU_ADD;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        pcSource  = 2'b00;
        pcEn      = 1'b0;
        iorD      = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        illegalOp = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                // Reset is applied directly so a ready cache cannot load PC/IR while rst_n is low.
                pcEn    = memReady & rst_n;
                irWrite = memReady & rst_n;
            end
            S_DECODE: begin
                aluSrcB   = 2'b11;
                illegalOp = w_op_illegal;
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXEC: begin
                aluSrcA   = 1'b1;
                aluCtr    = w_funct_alu;
                illegalOp = ~w_funct_ok;
            end
            S_RWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                aluCtr   = r_alu_ctr;
            end
            S_BRANCH: begin
                aluSrcA  = 1'b1;
                aluCtr   = ALU_SUB;
                pcSource = 2'b01;
                pcEn     = zero;
            end
            S_JUMP: begin
                pcSource = 2'b10;
                pcEn     = 1'b1;
            end
`ifdef MULTI_CTRL_ADDI_EN
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
            end
`endif
            default: begin
                aluCtr = ALU_ADD;
            end
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_multi_ctrl.sv
// Randomized instruction stream against a per-instruction reference of the expected cycle-by-cycle control outputs.
module tb_multi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opCode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic [3:0] aluCtr;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegalOp;
    logic [3:0] state;

    always #5 clk = ~clk;

    multi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .funct(funct), .zero(zero),
        .memReady(memReady), .aluCtr(aluCtr), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .pcSource(pcSource), .pcEn(pcEn), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
        .regWrite(regWrite), .illegalOp(illegalOp), .state(state)
    );

`ifdef MULTI_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic       a_src_a;
        logic [1:0] a_src_b;
        logic [1:0] pc_src;
        logic       pc_en, ior_d, m_rd, m_wr, ir_wr, r_dst, m2r, r_wr, ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic [3:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.alu = 4'b0010;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = '{state, aluCtr, aluSrcA, aluSrcB, pcSource, pcEn, iorD, memRead,
              memWrite, irWrite, regDst, memToReg, regWrite, illegalOp};
        return a;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // R-type function table: ok=0 for anything outside the six supported ops.
    function automatic logic [3:0] alu_of(input logic [5:0] fn, output bit ok);
        ok = 1'b1;
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default: begin
                ok = 1'b0;
                return 4'b0010;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Called at posedge+1: apply inputs for this cycle, queue its expectation, move to next cycle.
    task automatic drive(input logic mr, input logic z, input exp_t e);
        memReady = mr;
        zero     = z;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("cycle_state%0d", e.st), 64'(actual()), 64'(e));
        end
    end

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int n_f,
                             input int n_m, input bit abort_in_wr);
        exp_t e;
        bit   legal;
        bit   ok;
        logic z;
        logic [3:0] code;
        opCode = op;
        funct  = fn;
        for (int i = 0; i < n_f; i++) begin
            e = mk(0); e.m_rd = 1; e.a_src_b = 2'b01;
            drive(1'b0, rb(), e);
        end
        e = mk(0); e.m_rd = 1; e.a_src_b = 2'b01; e.pc_en = 1; e.ir_wr = 1;
        drive(1'b1, rb(), e);
        legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                (op == OP_J) || (ADDI_EN && op == OP_ADDI);
        e = mk(1); e.a_src_b = 2'b11; e.ill = !legal;
        drive(rb(), rb(), e);
        if (!legal) return;
        if (op == OP_LW || op == OP_SW) begin
            e = mk(2); e.a_src_a = 1; e.a_src_b = 2'b10;
            drive(rb(), rb(), e);
            for (int i = 0; i <= n_m; i++) begin
                if (op == OP_SW && abort_in_wr && i == n_m) return;
                e = (op == OP_LW) ? mk(3) : mk(5);
                e.ior_d = 1;
                if (op == OP_LW) e.m_rd = 1; else e.m_wr = 1;
                drive((i == n_m) ? 1'b1 : 1'b0, rb(), e);
            end
            if (op == OP_LW) begin
                e = mk(4); e.r_wr = 1; e.m2r = 1;
                drive(rb(), rb(), e);
            end
        end else if (op == OP_R) begin
            code = alu_of(fn, ok);
            e = mk(6); e.a_src_a = 1; e.alu = code; e.ill = !ok;
            drive(rb(), rb(), e);
            if (ok) begin
                e = mk(7); e.r_wr = 1; e.r_dst = 1; e.alu = code;
                drive(rb(), rb(), e);
            end
        end else if (op == OP_BEQ) begin
            z = rb();
            e = mk(8); e.a_src_a = 1; e.alu = 4'b0110; e.pc_src = 2'b01; e.pc_en = z;
            drive(rb(), z, e);
        end else if (op == OP_J) begin
            e = mk(9); e.pc_src = 2'b10; e.pc_en = 1;
            drive(rb(), rb(), e);
        end else begin
            e = mk(10); e.a_src_a = 1; e.a_src_b = 2'b10;
            drive(rb(), rb(), e);
            e = mk(11); e.r_wr = 1;
            drive(rb(), rb(), e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       rst_e;
        logic [5:0] op;
        logic [5:0] fn;
        bit         ok;
        int         kind;
        rst_e = mk(0); rst_e.m_rd = 1; rst_e.a_src_b = 2'b01;

        rst_n = 1'b0; opCode = '0; funct = '0; zero = 1'b1; memReady = 1'b1;
        #2;
        check("reset_outputs", 64'(actual()), 64'(rst_e));
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 64'(actual()), 64'(rst_e));
        rst_n = 1'b1;

        // Directed: first edge after reset advances, then the named scenarios.
        run_instr(OP_R, 6'b100000, 0, 0, 1'b0);
        run_instr(OP_LW, 6'b000000, 0, 3, 1'b0);
        run_instr(OP_BEQ, 6'b000000, 1, 0, 1'b0);
        run_instr(6'b111111, 6'b100000, 0, 0, 1'b0);
        run_instr(OP_R, 6'b000000, 2, 0, 1'b0);
        run_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0);
        run_instr(OP_SW, 6'b000000, 1, 2, 1'b0);

        for (int n = 0; n < 160; n++) begin
            kind = int'($urandom_range(0, 8));
            fn   = 6'($urandom_range(0, 63));
            case (kind)
                0, 1: begin
                    op = OP_R;
                    void'(alu_of(fn, ok));
                    if (!ok && $urandom_range(0, 3) != 0) fn = 6'b100010 ^ 6'(($urandom_range(0, 1)) << 1);
                end
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_BEQ;
                5: op = OP_J;
                6: op = OP_ADDI;
                7: op = OP_R;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                           op == OP_J || op == OP_ADDI)
                        op = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Asynchronous reset while a store is stalled on the cache.
        run_instr(OP_SW, 6'b000000, 1, 2, 1'b1);
        memReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_in_memwr", 64'(actual()), 64'(rst_e));
        memReady = 1'b1;
        #1;
        check("reset_gates_pcen", 64'(actual()), 64'(rst_e));
        @(posedge clk);
        #1;
        check("reset_hold_edge", 64'(actual()), 64'(rst_e));
        rst_n = 1'b1;
        run_instr(OP_J, 6'b000000, 0, 0, 1'b0);
        run_instr(OP_R, 6'b100111, 1, 0, 1'b0);

        @(negedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 SHALL have ports:
- clk, input, 1, single system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- opCode, input, 6, instruction bits [31:26] from the instruction register.
- funct, input, 6, instruction bits [5:0].
- zero, input, 1, ALU zero flag.
- memReady, input, 1, cache access complete this cycle.
- aluCtr, output, 4, ALU operation code.
- aluSrcA, output, 1; aluSrcB, output, 2; pcSource, output, 2; operand and next-PC selects.
- pcEn, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, output, 1 each, datapath strobes.
- illegalOp, output, 1, one-cycle pulse on an undecodable instruction.
- state, output, 4, current FSM state, for debug.

REQ-002 The aluCtr encoding SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.

Function
REQ-003 The FSM SHALL use these states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
REQ-004 Outputs SHALL be Moore, decoded from state only, except pcEn and the FETCH-to-DECODE advance, which are gated by memReady and zero.
REQ-005 FETCH SHALL drive memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtr=ADD, pcSource=00.
- irWrite=1 and pcEn=1 only in a cycle with memReady=1.
- The FSM SHALL hold in FETCH while memReady=0.
REQ-006 DECODE SHALL drive aluSrcA=0, aluSrcB=11, aluCtr=ADD, lasting one cycle. It SHALL then branch on opCode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDIEX (macro-dependent, see REQ-015)
- anything else -> FETCH with illegalOp=1 for that cycle.
REQ-007 MEMADR SHALL drive aluSrcA=1, aluSrcB=10, aluCtr=ADD. Next state is MEMRD for opCode 100011, otherwise MEMWR.
REQ-008 MEMRD SHALL drive memRead=1, iorD=1, and hold until memReady=1, then go to MEMWB.
- MEMWB SHALL drive regWrite=1, memToReg=1, regDst=0, then go to FETCH.
REQ-009 MEMWR SHALL drive memWrite=1, iorD=1, and hold until memReady=1, then go to FETCH.
REQ-010 EXEC SHALL drive aluSrcA=1, aluSrcB=00, with aluCtr decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
- Any other funct SHALL go to FETCH with illegalOp=1 and no register write.
- A valid funct SHALL go to RWB.
REQ-011 RWB SHALL drive regWrite=1, regDst=1, memToReg=0, hold aluCtr from EXEC, then go to FETCH.
REQ-012 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluCtr=SUB, pcSource=01, pcEn=zero, then go to FETCH.
REQ-013 JUMP SHALL drive pcSource=10, pcEn=1, then go to FETCH.
REQ-014 In any state not listed above, all strobes SHALL be 0, aluCtr=ADD, and the next state SHALL be FETCH.

Reset
REQ-016 On rst_n=0, the FSM SHALL go to FETCH immediately and asynchronously, including mid-instruction or mid-memory-wait. The internally registered funct-derived aluCtr SHALL reset to 0010 (ADD).
REQ-017 While rst_n=0, all outputs SHALL be 0 except the FETCH-state values aluCtr=0010, aluSrcB=01, memRead=1.
- pcEn and irWrite SHALL be forced to 0 regardless of memReady.
REQ-018 The first state advance after reset SHALL occur on the first rising clk edge with rst_n=1.

Configuration
REQ-015 Macro MULTI_CTRL_ADDI_EN SHALL control addi support.
- Defined: opCode 001000 -> ADDIEX (aluSrcA=1, aluSrcB=10, aluCtr=ADD) -> ADDIWB (regWrite=1, regDst=0, memToReg=0) -> FETCH.
- Undefined: 001000 is illegal per REQ-006, and states 10 and 11 are unreachable.

Verification
REQ-019 R-type add (opCode 000000, funct 100000), memReady=1 in FETCH -> state sequence 0,1,6,7,0; aluCtr=0010 in EXEC and RWB; regWrite=1, regDst=1 in RWB.
REQ-020 lw (100011), memReady low for 3 cycles in MEMRD -> state sequence 0,1,2,3,3,3,3,4,0; memRead=1 and iorD=1 throughout MEMRD; regWrite=1, memToReg=1 in MEMWB.
REQ-021 beq (000100): with zero=1, pcEn=1 and pcSource=01 in BRANCH; with zero=0, pcEn=0; both cases then return to FETCH.
REQ-022 opCode 111111 -> illegalOp=1 for exactly the DECODE cycle, then FETCH; R-type funct 000000 -> illegalOp=1 in EXEC; no regWrite/memWrite in either case.
REQ-023 rst_n pulsed low during MEMWR with memReady=0 -> state=0 and memWrite=0 before the next clk edge; the instruction is not retired.
REQ-024 addi (001000), macro defined -> states 0,1,10,11,0 with regWrite=1 in ADDIWB; macro undefined -> illegalOp=1 in DECODE.
